// File: rtl/y_out_buffer.sv
// rtl/y_out_buffer.sv - four-lane result collector with round-robin serializing drain
//
// Purpose:
//   Captures four signed lane results (one set per y_capture strobe) into
//   DEPTH-entry per-lane stores. When all DEPTH entries are filled, the
//   buffer drains them one word per handshake in the order lane1, lane2,
//   lane3, lane4, then the next entry, until 4*DEPTH words have gone out.
//   The buffer then returns to filling.
//
// Build option:
//   YBUF_SAT_EN - when defined, each lane is signed-saturated to OUT_W bits
//                 before storage and sat_seen latches any clip. When it is
//                 undefined, the low OUT_W bits are stored (wrap) and
//                 sat_seen is tied low.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   y_in1..4   signed lane results, IN_W bits each
//   y_capture  capture strobe for all four lanes (honoured only in FILL)
//   cap_ready  high while captures are accepted (FILL)
//   out_data   serialized word, combinational from storage during DRAIN
//   out_valid  out_data is valid (DRAIN)
//   out_ready  downstream accepts out_data
//   drain_done one-cycle pulse on the final output handshake
//   sat_seen   sticky saturation flag (YBUF_SAT_EN builds only)

module y_out_buffer #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    y_in1,
  input  logic [IN_W-1:0]    y_in2,
  input  logic [IN_W-1:0]    y_in3,
  input  logic [IN_W-1:0]    y_in4,
  input  logic               y_capture,
  output logic               cap_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               drain_done,
  output logic               sat_seen
);

  localparam int CW = $clog2(DEPTH);
  localparam int RW = $clog2(4 * DEPTH);
  localparam logic [CW-1:0] CAP_LAST = CW'(DEPTH - 1);
  localparam logic [RW-1:0] RD_LAST  = RW'(4 * DEPTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cap_count;
  logic [RW-1:0]   rd_idx;
  logic            cap_fire;
  logic            out_fire;

  logic [OUT_W-1:0] mem [4][DEPTH];
  logic [OUT_W-1:0] conv_w [4];

`ifdef YBUF_SAT_EN
  logic [3:0] clip;
  logic       sat_reg;

  // A value fits in OUT_W signed bits when every bit from the OUT_W sign
  // position upward is a copy of the sign.
  function automatic logic does_clip(input logic [IN_W-1:0] v);
    logic [IN_W-OUT_W:0] hi;
    hi = v[IN_W-1:OUT_W-1];
    return !((&hi) || (~|hi));
  endfunction

  function automatic logic [OUT_W-1:0] sat_conv(input logic [IN_W-1:0] v);
    if (!does_clip(v))
      return v[OUT_W-1:0];
    else if (v[IN_W-1])
      return {1'b1, {(OUT_W-1){1'b0}}};
    else
      return {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  always_comb begin
    conv_w[0] = sat_conv(y_in1);
    conv_w[1] = sat_conv(y_in2);
    conv_w[2] = sat_conv(y_in3);
    conv_w[3] = sat_conv(y_in4);
    clip      = {does_clip(y_in4), does_clip(y_in3), does_clip(y_in2), does_clip(y_in1)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sat_reg <= 1'b0;
    else if (cap_fire && (|clip))
      sat_reg <= 1'b1;
  end

  assign sat_seen = sat_reg;
`else
  logic unused_hi;

  // Wrap conversion keeps only the low OUT_W bits; the upper bits are
  // intentionally dropped.
  assign unused_hi = ^{y_in1, y_in2, y_in3, y_in4};

  always_comb begin
    conv_w[0] = y_in1[OUT_W-1:0];
    conv_w[1] = y_in2[OUT_W-1:0];
    conv_w[2] = y_in3[OUT_W-1:0];
    conv_w[3] = y_in4[OUT_W-1:0];
  end

  assign sat_seen = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FILL;
    else
      state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    cap_ready  = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    drain_done = 1'b0;
    cap_fire   = 1'b0;
    out_fire   = 1'b0;
    case (state)
      FILL: begin
        cap_ready = 1'b1;
        if (y_capture) begin
          cap_fire = 1'b1;
          if (cap_count == CAP_LAST)
            state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        // Low two index bits pick the lane, the rest pick the entry.
        out_data  = mem[rd_idx[1:0]][rd_idx[RW-1:2]];
        if (out_ready) begin
          out_fire = 1'b1;
          if (rd_idx == RD_LAST) begin
            drain_done = 1'b1;
            state_nxt  = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Counters. Both ranges are powers of two, so the natural wrap of the
  // increment returns them to 0 exactly on the last capture / last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_count <= '0;
      rd_idx    <= '0;
    end else begin
      if (cap_fire)
        cap_count <= cap_count + 1'b1;
      if (out_fire)
        rd_idx <= rd_idx + 1'b1;
    end
  end

  // Lane storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < 4; l++)
        for (int e = 0; e < DEPTH; e++)
          mem[l][e] <= '0;
    end else if (cap_fire) begin
      for (int l = 0; l < 4; l++)
        mem[l][cap_count] <= conv_w[l];
    end
  end

endmodule

// File: tb/tb_y_out_buffer.sv
// tb/tb_y_out_buffer.sv - randomized self-checking bench for y_out_buffer

module tb_y_out_buffer;

  localparam int IN_W  = 19;
  localparam int OUT_W = 16;
  localparam int DEPTH = 8;
  localparam int NW    = 4 * DEPTH;

  logic              clk;
  logic              rst;
  logic [IN_W-1:0]   y_in1, y_in2, y_in3, y_in4;
  logic              y_capture;
  logic              cap_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              drain_done;
  logic              sat_seen;

  y_out_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .y_in1(y_in1), .y_in2(y_in2), .y_in3(y_in3), .y_in4(y_in4),
    .y_capture(y_capture), .cap_ready(cap_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drain_done(drain_done), .sat_seen(sat_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: captured words are queued in drain order; a full
  // frame becomes the expected output queue.
  bit          m_drain = 1'b0;
  bit          m_sat   = 1'b0;
  logic [15:0] pend[$];
  logic [15:0] expq[$];
  logic [15:0] obs_log[$];

  function automatic bit mclip(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  function automatic logic [15:0] mconv(input int v);
`ifdef YBUF_SAT_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_drain = 1'b0;
      m_sat   = 1'b0;
      pend.delete();
      expq.delete();
    end else if (m_drain) begin
      if (out_ready) begin
        void'(expq.pop_front());
        if (expq.size() == 0) m_drain = 1'b0;
      end
    end else if (y_capture) begin
      int v[4];
      v[0] = int'($signed(y_in1));
      v[1] = int'($signed(y_in2));
      v[2] = int'($signed(y_in3));
      v[3] = int'($signed(y_in4));
      for (int l = 0; l < 4; l++) begin
        pend.push_back(mconv(v[l]));
`ifdef YBUF_SAT_EN
        if (mclip(v[l])) m_sat = 1'b1;
`endif
      end
      if (pend.size() == NW) begin
        expq = pend;
        pend.delete();
        m_drain = 1'b1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("cap_ready", int'(cap_ready), int'(!m_drain));
    chk("out_valid", int'(out_valid), int'(m_drain));
    chk("out_data", int'(out_data), m_drain ? int'(expq[0]) : 0);
    chk("drain_done", int'(drain_done), int'(m_drain && out_ready && expq.size() == 1));
    chk("sat_seen", int'(sat_seen), int'(m_sat));
    if (out_valid && out_ready) obs_log.push_back(out_data);
  end

  // out_ready driver: 0 = always high, 1 = 1,0,0 pattern, 2 = random.
  int rdy_mode = 0;
  initial begin
    int phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin out_ready = (phase == 0); phase = (phase + 1) % 3; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic cap(input int a, input int b, input int c, input int d);
    y_in1 = 19'(a); y_in2 = 19'(b); y_in3 = 19'(c); y_in4 = 19'(d);
    y_capture = 1'b1;
    @(posedge clk);
    #1;
    y_capture = 1'b0;
  endtask

  task automatic fill_ramp(input int base);
    for (int k = 0; k < DEPTH; k++) cap(base + k, base + 16 + k, base + 32 + k, base + 48 + k);
  endtask

  task automatic rnd_val(output int v);
    v = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
  endtask

  task automatic wait_drain();
    bit seen = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (drain_done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ramp(input string nm, input int base);
    chk({nm, "_count"}, obs_log.size(), NW);
    for (int i = 0; i < NW && i < obs_log.size(); i++)
      chk(nm, int'(obs_log[i]), base + (i % 4) * 16 + i / 4);
  endtask

  initial begin
    rst = 1'b0;
    y_capture = 1'b0;
    y_in1 = '0; y_in2 = '0; y_in3 = '0; y_in4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cap_ready", int'(cap_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    rst = 1'b1;

    // 1: basic fill and drain with literal word expectations.
    obs_log.delete();
    fill_ramp(0);
    wait_drain();
    chk("s1_w0", int'(obs_log[0]), 0);
    chk("s1_w1", int'(obs_log[1]), 16);
    chk("s1_w3", int'(obs_log[3]), 48);
    chk("s1_w4", int'(obs_log[4]), 1);
    chk("s1_w31", int'(obs_log[31]), 55);
    chk("s1_cap_ready_after", int'(cap_ready), 1);

    // 2: backpressure.
    rdy_mode = 1;
    obs_log.delete();
    fill_ramp(0);
    wait_drain();
    chk_ramp("s2_word", 0);

    // 3: captures during drain are ignored; next frame starts at entry 0.
    obs_log.delete();
    fill_ramp(0);
    y_in1 = 19'h7FF;
    y_capture = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    y_capture = 1'b0;
    wait_drain();
    chk_ramp("s3_word", 0);
    obs_log.delete();
    fill_ramp(100);
    wait_drain();
    chk("s3_next_w0", int'(obs_log[0]), 100);

    // 4: overflow handling.
    rdy_mode = 0;
    obs_log.delete();
    cap(40000, -40000, -1, 32767);
    for (int k = 1; k < DEPTH; k++) cap(k, k, k, k);
    wait_drain();
`ifdef YBUF_SAT_EN
    chk("s4_w0", int'(obs_log[0]), 'h7FFF);
    chk("s4_w1", int'(obs_log[1]), 'h8000);
    chk("s4_w2", int'(obs_log[2]), 'hFFFF);
    chk("s4_w3", int'(obs_log[3]), 'h7FFF);
    chk("s4_sat", int'(sat_seen), 1);
`else
    chk("s4_w0", int'(obs_log[0]), 'h9C40);
    chk("s4_w1", int'(obs_log[1]), 'h63C0);
    chk("s4_w2", int'(obs_log[2]), 'hFFFF);
    chk("s4_w3", int'(obs_log[3]), 'h7FFF);
    chk("s4_sat", int'(sat_seen), 0);
`endif

    // 5: reset after five handshakes.
    obs_log.delete();
    fill_ramp(0);
    for (int n = 0; n < 200 && obs_log.size() < 5; n++) @(negedge clk);
    chk("s5_reached5", int'(obs_log.size() >= 5), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s5_out_valid", int'(out_valid), 0);
    chk("s5_cap_ready", int'(cap_ready), 1);
    chk("s5_out_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs_log.delete();
    fill_ramp(200);
    wait_drain();
    chk("s5_new_w0", int'(obs_log[0]), 200);
    chk("s5_new_count", obs_log.size(), NW);

    // 6: back-to-back random frames with random backpressure and gaps.
    rdy_mode = 2;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < DEPTH; k++) begin
        int a, b, c, d;
        rnd_val(a); rnd_val(b); rnd_val(c); rnd_val(d);
        if (f >= 2 && $urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        cap(a, b, c, d);
      end
      wait_drain();
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
